// File: rtl/ram_dp_be_sr_sw.sv
// Simple dual-port RAM: one byte-enabled write port, one read port with 1 or 2
// cycle latency, selectable read-during-write result and a zeroing sweep after reset.
module ram_dp_be_sr_sw #(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_NEW        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             busy
);

  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_addr, clr_addr_nxt;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

  logic                    idle, wr_fire, rd_fire, rd_in_range;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    vld_p0, vld_p1;
  logic [DATA_WIDTH-1:0]   data_p0, data_p1;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [LANES-1:0]      be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < LANES; i++)
      if (be[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    return res;
  endfunction

  assign idle        = (state == S_IDLE);
  assign busy        = (state == S_CLEAR);
  assign wr_fire     = idle && wr_en && ({1'b0, wr_addr} < DEPTH_LIM);
  assign rd_fire     = idle && rd_en;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    if (state == S_CLEAR) begin
      if (clr_addr == CLR_LAST) begin
        state_nxt    = S_IDLE;
        clr_addr_nxt = '0;
      end else begin
        clr_addr_nxt = clr_addr + 1'b1;
      end
    end
  end

  // Array: the sweep owns the write port until it finishes.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)
      mem[clr_addr] <= '0;
    else if (wr_fire)
      mem[wr_addr] <= merge_lanes(mem[wr_addr], wr_data, wr_be);
  end

  // Out-of-range reads answer 0; a same-address write can be forwarded in.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
      if ((RDW_NEW != 0) && wr_fire && (wr_addr == rd_addr))
        rd_word = merge_lanes(mem[rd_addr], wr_data, wr_be);
    end
  end

  // Stage p0: registered array read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= rd_fire;
      if (rd_fire) data_p0 <= rd_word;
    end
  end

  // Stage p1: optional output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) data_p1 <= data_p0;
    end
  end

  assign rd_valid = (READ_LATENCY == 2) ? vld_p1  : vld_p0;
  assign rd_data  = (READ_LATENCY == 2) ? data_p1 : data_p0;

endmodule

// File: tb/tb_ram_dp_be_sr_sw.sv
// Bench for ram_dp_be_sr_sw: two instances (latency 1 / old-data, latency 2 / new-data)
// share one stimulus stream; a reference array and per-instance queues give expectations.
module tb_ram_dp_be_sr_sw;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0]    wr_be = '0;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1, busy0, busy1;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] model [32];
  logic [DW-1:0] last0 = '0, last1 = '0;
  int            checks = 0, errors = 0, cyc = 0, sweep_left = DEPTH;

  ram_dp_be_sr_sw #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
                    .READ_LATENCY(1), .RDW_NEW(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0));

  ram_dp_be_sr_sw #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
                    .READ_LATENCY(2), .RDW_NEW(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [3:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_port(input int id, input logic v, input logic [DW-1:0] d);
    exp_t e;
    logic exp_v;
    if (id == 0) exp_v = (q0.size() > 0) && (q0[0].due == cyc);
    else         exp_v = (q1.size() > 0) && (q1[0].due == cyc);
    check_eq((id == 0) ? "rd_valid0" : "rd_valid1", {31'b0, v}, {31'b0, exp_v});
    if (exp_v) begin
      if (id == 0) begin
        e = q0.pop_front();
        last0 = e.data;
      end else begin
        e = q1.pop_front();
        last1 = e.data;
      end
      check_eq((id == 0) ? "rd_data0" : "rd_data1", d, e.data);
    end else begin
      check_eq((id == 0) ? "rd_hold0" : "rd_hold1", d, (id == 0) ? last0 : last1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst && sweep_left > 0) sweep_left--;
    cyc++;
    #1;
    check_eq("busy0", {31'b0, busy0}, {31'b0, (sweep_left > 0)});
    check_eq("busy1", {31'b0, busy1}, {31'b0, (sweep_left > 0)});
    check_port(0, rd_valid0, rd_data0);
    check_port(1, rd_valid1, rd_data1);
  endtask

  task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd, input logic [3:0] be,
                       input bit re, input int ra);
    exp_t e0, e1;
    bit   accept;
    accept  = !rst && (sweep_left == 0);
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_data = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = AW'(ra);
    if (accept && re) begin
      e0.data = (ra < DEPTH) ? model[ra] : '0;
      e1.data = e0.data;
      if (we && wa == ra && wa < DEPTH) e1.data = lane_merge(model[ra], wd, be);
      e0.due = cyc + 1;
      e1.due = cyc + 2;
      q0.push_back(e0);
      q1.push_back(e1);
    end
    if (accept && we && wa < DEPTH) model[wa] = lane_merge(model[wa], wd, be);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, 4'h0, 0, 0);
  endtask

  task automatic reset_pulse(input int n);
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    sweep_left = DEPTH;
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  initial begin
    #2;
    reset_pulse(2);

    // Requests during the sweep must be ignored (addr 0 is already swept when hit again).
    for (int i = 0; i < DEPTH; i++) drive(1, 0, 32'h12345678, 4'hF, 1, i);

    // Every word reads back as zero, streamed back to back.
    for (int i = 0; i < DEPTH; i++) drive(0, 0, '0, 4'h0, 1, i);
    idle(3);

    // Byte-enable merge, then an all-lanes-off write overlapping a read.
    drive(1, 5, 32'hAABBCCDD, 4'hF, 0, 0);
    drive(1, 5, 32'h11223344, 4'h5, 0, 0);
    drive(1, 5, 32'hFFFFFFFF, 4'h0, 1, 5);
    drive(0, 0, '0, 4'h0, 1, 5);
    idle(2);

    // Read-during-write on addr 3, then an independent write/read pair.
    drive(1, 3, 32'h01020304, 4'hF, 0, 0);
    drive(1, 3, 32'hFFFFFFFF, 4'h3, 1, 3);
    drive(1, 7, 32'h55AA55AA, 4'hF, 1, 3);
    drive(0, 0, '0, 4'h0, 1, 7);
    idle(2);

    // Streaming reads of addr*3.
    for (int i = 0; i < 8; i++) drive(1, i, DW'(i * 3), 4'hF, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, '0, 4'h0, 1, i);
    idle(4);
    check_eq("hold21_0", rd_data0, 32'd21);
    check_eq("hold21_1", rd_data1, 32'd21);

    // Out-of-range write dropped, out-of-range read answers 0.
    drive(1, 25, 32'hDEADBEEF, 4'hF, 0, 0);
    drive(0, 0, '0, 4'h0, 1, 25);
    for (int i = 0; i < DEPTH; i++) drive(0, 0, '0, 4'h0, 1, i);
    idle(3);

    // Read in flight when reset hits must not surface.
    drive(0, 0, '0, 4'h0, 1, 3);
    reset_pulse(2);

    // Reset at sweep address 9 restarts the full sweep.
    idle(9);
    reset_pulse(1);
    idle(DEPTH);
    drive(0, 0, '0, 4'h0, 1, 3);
    drive(0, 0, '0, 4'h0, 1, 5);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
